adc_capture_ctrl: RTL

- Triggered two-channel capture sequencer for the 12-bit AD9238 sample stream.
- Sits after the ADC front-end in the sys_clk domain, alongside the loopback DAC path.
- Arms on CSR command, fills a pre-trigger history, waits for a software or level trigger, then records a post-trigger window into an internal circular buffer.
- Firmware reads the buffer through a registered read port.

---
 rtl/adc_capture_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// Triggered two-channel capture sequencer: pre-trigger history, software/level
// trigger, post-trigger window into a circular buffer with a registered read port.
module adc_capture_ctrl #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DW         = 12
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  sample_en,
  input  logic [DW-1:0]         adc_ch0,
  input  logic [DW-1:0]         adc_ch1,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  sw_trig,
  input  logic [1:0]            trig_src,
  input  logic [DW-1:0]         trig_level,
  input  logic [DEPTH_LOG2:0]   pre_count,
  input  logic [DEPTH_LOG2:0]   post_count,
  output logic [2:0]            state,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic [DEPTH_LOG2-1:0] start_addr,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [2*DW-1:0]       rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                  r_state;
  logic                    r_done;
  logic [DEPTH_LOG2-1:0]   r_trig_addr;
  logic [DEPTH_LOG2-1:0]   r_start_addr;
  logic [DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [DEPTH_LOG2:0]     r_cnt;
  logic [DEPTH_LOG2:0]     r_pre;
  logic [DEPTH_LOG2:0]     r_post;
  logic [1:0]              r_src;
  logic [DW-1:0]           r_level;
  logic [DW-1:0]           r_prev;
  logic                    r_prev_valid;
  logic                    r_sw_lat;
  logic [2*DW-1:0]         r_rd_data;
  logic [2*DW-1:0]         r_mem [DEPTH];

  logic                    w_active;
  logic                    w_wr;
  logic [DW-1:0]           w_sel;
  logic                    w_sw_fire;
  logic                    w_lvl_fire;
  logic                    w_trig;
  logic [DEPTH_LOG2:0]     w_cnt_inc;

  always_comb begin
    w_active   = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
    w_wr       = sample_en && w_active;
    w_sel      = (r_src == 2'd2) ? adc_ch1 : adc_ch0;
    // Source 3 is reserved and falls back to the software trigger.
    w_sw_fire  = ((r_src == 2'd0) || (r_src == 2'd3)) && (sw_trig || r_sw_lat);
    w_lvl_fire = ((r_src == 2'd1) || (r_src == 2'd2)) && r_prev_valid &&
                 (r_prev < r_level) && (w_sel >= r_level);
    w_trig     = w_wr && (r_state == S_WAIT) && (w_sw_fire || w_lvl_fire);
    w_cnt_inc  = r_cnt + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_done       <= 1'b0;
      r_trig_addr  <= '0;
      r_start_addr <= '0;
      r_wr_ptr     <= '0;
      r_cnt        <= '0;
      r_pre        <= '0;
      r_post       <= '0;
      r_src        <= '0;
      r_level      <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_sw_lat     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr     <= r_wr_ptr + 1'b1;
        r_prev       <= w_sel;
        r_prev_valid <= 1'b1;
      end
      if (abort) begin
        r_state <= S_IDLE;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (arm) begin
              r_state      <= S_PRE;
              r_wr_ptr     <= '0;
              r_cnt        <= '0;
              r_done       <= 1'b0;
              r_sw_lat     <= 1'b0;
              r_prev_valid <= 1'b0;
              r_pre        <= pre_count;
              r_post       <= (post_count == '0) ? CNT_ONE : post_count;
              r_src        <= trig_src;
              r_level      <= trig_level;
            end
          end
          S_PRE: begin
            if (r_cnt == r_pre) r_state <= S_WAIT;
            else if (w_wr)      r_cnt   <= w_cnt_inc;
          end
          S_WAIT: begin
            if (w_trig) begin
              r_trig_addr  <= r_wr_ptr;
              r_start_addr <= r_wr_ptr - r_pre[DEPTH_LOG2-1:0];
              r_cnt        <= CNT_ONE;
              if (r_post == CNT_ONE) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_POST;
              end
            end else if (sw_trig) begin
              r_sw_lat <= 1'b1;
            end
          end
          S_POST: begin
            if (w_wr) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == r_post) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= {adc_ch1, adc_ch0};
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[rd_addr];
  end

  assign state      = r_state;
  assign done       = r_done;
  assign trig_addr  = r_trig_addr;
  assign start_addr = r_start_addr;
  assign rd_data    = r_rd_data;

endmodule
